// File: rtl/axi_lite_arb_pkg.sv
// Shared types for the AXI4-Lite round-robin arbiter: FSM state encodings and response width.
package axi_lite_arb_pkg;

  localparam int unsigned RespWidth = 2;
  typedef logic [RespWidth-1:0] resp_t;

  typedef enum logic [1:0] {WIdle, WFwd, WResp} wr_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;

endpackage

// File: rtl/rr_arb_select.sv
// Combinational round-robin winner: first asserted request at or after ptr_i, wrapping.
module rr_arb_select #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NumReq);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// Shares one AXI4-Lite slave among NUM_REQ masters; read and write directions are arbitrated
// independently, one outstanding transaction each, grant held until the response handshake.
module axi_lite_rr_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]        m_aw_addr,
  input  logic [NUM_REQ-1:0][2:0]                   m_aw_prot,
  input  logic [NUM_REQ-1:0]                        m_aw_valid,
  output logic [NUM_REQ-1:0]                        m_aw_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]        m_w_data,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]      m_w_strb,
  input  logic [NUM_REQ-1:0]                        m_w_valid,
  output logic [NUM_REQ-1:0]                        m_w_ready,
  output logic [NUM_REQ-1:0][RespWidth-1:0]         m_b_resp,
  output logic [NUM_REQ-1:0]                        m_b_valid,
  input  logic [NUM_REQ-1:0]                        m_b_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]        m_ar_addr,
  input  logic [NUM_REQ-1:0][2:0]                   m_ar_prot,
  input  logic [NUM_REQ-1:0]                        m_ar_valid,
  output logic [NUM_REQ-1:0]                        m_ar_ready,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]        m_r_data,
  output logic [NUM_REQ-1:0][RespWidth-1:0]         m_r_resp,
  output logic [NUM_REQ-1:0]                        m_r_valid,
  input  logic [NUM_REQ-1:0]                        m_r_ready,
  output logic [ADDR_WIDTH-1:0]                     s_aw_addr,
  output logic [2:0]                                s_aw_prot,
  output logic                                      s_aw_valid,
  input  logic                                      s_aw_ready,
  output logic [DATA_WIDTH-1:0]                     s_w_data,
  output logic [DATA_WIDTH/8-1:0]                   s_w_strb,
  output logic                                      s_w_valid,
  input  logic                                      s_w_ready,
  input  logic [RespWidth-1:0]                      s_b_resp,
  input  logic                                      s_b_valid,
  output logic                                      s_b_ready,
  output logic [ADDR_WIDTH-1:0]                     s_ar_addr,
  output logic [2:0]                                s_ar_prot,
  output logic                                      s_ar_valid,
  input  logic                                      s_ar_ready,
  input  logic [DATA_WIDTH-1:0]                     s_r_data,
  input  logic [RespWidth-1:0]                      s_r_resp,
  input  logic                                      s_r_valid,
  output logic                                      s_r_ready,
  output logic                                      wr_busy_o,
  output logic                                      rd_busy_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  wr_state_e       wr_state_q, wr_state_d;
  rd_state_e       rd_state_q, rd_state_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [IdxW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            wr_sel_valid, rd_sel_valid;
  logic [IdxW-1:0] wr_sel_idx, rd_sel_idx;
  logic            fwd_aw, fwd_w, in_wresp, fwd_ar, in_rdata;

  function automatic logic [IdxW-1:0] next_idx(logic [IdxW-1:0] idx);
    return (32'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // Only AW requests arbitrate writes; a lone W waits for its master's AW grant.
  rr_arb_select #(.NumReq(NUM_REQ), .IdxW(IdxW)) u_wr_sel (
    .req_i   (m_aw_valid),
    .ptr_i   (wr_ptr_q),
    .valid_o (wr_sel_valid),
    .idx_o   (wr_sel_idx)
  );

  rr_arb_select #(.NumReq(NUM_REQ), .IdxW(IdxW)) u_rd_sel (
    .req_i   (m_ar_valid),
    .ptr_i   (rd_ptr_q),
    .valid_o (rd_sel_valid),
    .idx_o   (rd_sel_idx)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_state_q <= WIdle;
      rd_state_q <= RIdle;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Forwarding qualifiers; a channel is masked once its handshake has completed.
  assign fwd_aw   = (wr_state_q == WFwd) && !aw_done_q;
  assign fwd_w    = (wr_state_q == WFwd) && !w_done_q;
  assign in_wresp = (wr_state_q == WResp);
  assign fwd_ar   = (rd_state_q == RAddr);
  assign in_rdata = (rd_state_q == RData);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_ptr_d   = wr_ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    unique case (wr_state_q)
      WIdle: begin
        if (wr_sel_valid) begin
          wr_idx_d   = wr_sel_idx;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = WFwd;
        end
      end
      WFwd: begin
        if (s_aw_valid && s_aw_ready) aw_done_d = 1'b1;
        if (s_w_valid && s_w_ready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)    wr_state_d = WResp;
      end
      WResp: begin
        if (s_b_valid && s_b_ready) begin
          wr_ptr_d   = next_idx(wr_idx_q);
          wr_state_d = WIdle;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_ptr_d   = rd_ptr_q;
    unique case (rd_state_q)
      RIdle: begin
        if (rd_sel_valid) begin
          rd_idx_d   = rd_sel_idx;
          rd_state_d = RAddr;
        end
      end
      RAddr: if (s_ar_valid && s_ar_ready) rd_state_d = RData;
      RData: begin
        if (s_r_valid && s_r_ready) begin
          rd_ptr_d   = next_idx(rd_idx_q);
          rd_state_d = RIdle;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    s_aw_valid = fwd_aw & m_aw_valid[wr_idx_q];
    s_aw_addr  = fwd_aw ? m_aw_addr[wr_idx_q] : '0;
    s_aw_prot  = fwd_aw ? m_aw_prot[wr_idx_q] : '0;
    s_w_valid  = fwd_w & m_w_valid[wr_idx_q];
    s_w_data   = fwd_w ? m_w_data[wr_idx_q] : '0;
    s_w_strb   = fwd_w ? m_w_strb[wr_idx_q] : '0;
    s_b_ready  = in_wresp & m_b_ready[wr_idx_q];
    s_ar_valid = fwd_ar & m_ar_valid[rd_idx_q];
    s_ar_addr  = fwd_ar ? m_ar_addr[rd_idx_q] : '0;
    s_ar_prot  = fwd_ar ? m_ar_prot[rd_idx_q] : '0;
    s_r_ready  = in_rdata & m_r_ready[rd_idx_q];
  end

  always_comb begin
    m_aw_ready           = '0;
    m_w_ready            = '0;
    m_b_valid            = '0;
    m_b_resp             = '0;
    m_ar_ready           = '0;
    m_r_valid            = '0;
    m_r_data             = '0;
    m_r_resp             = '0;
    m_aw_ready[wr_idx_q] = fwd_aw & s_aw_ready;
    m_w_ready[wr_idx_q]  = fwd_w & s_w_ready;
    m_b_valid[wr_idx_q]  = in_wresp & s_b_valid;
    m_b_resp[wr_idx_q]   = in_wresp ? s_b_resp : '0;
    m_ar_ready[rd_idx_q] = fwd_ar & s_ar_ready;
    m_r_valid[rd_idx_q]  = in_rdata & s_r_valid;
    m_r_data[rd_idx_q]   = in_rdata ? s_r_data : '0;
    m_r_resp[rd_idx_q]   = in_rdata ? s_r_resp : '0;
  end

  assign wr_busy_o = (wr_state_q != WIdle);
  assign rd_busy_o = (rd_state_q != RIdle);

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter: the bench plays both masters and the slave by hand.
module tb_axi_lite_rr_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic [N-1:0][AW-1:0]      m_aw_addr, m_ar_addr;
  logic [N-1:0][2:0]         m_aw_prot, m_ar_prot;
  logic [N-1:0]              m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic [N-1:0][DW-1:0]      m_w_data, m_r_data;
  logic [N-1:0][DW/8-1:0]    m_w_strb;
  logic [N-1:0][1:0]         m_b_resp, m_r_resp;
  logic [N-1:0]              m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [AW-1:0]             s_aw_addr, s_ar_addr;
  logic [2:0]                s_aw_prot, s_ar_prot;
  logic                      s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
  logic [DW-1:0]             s_w_data, s_r_data;
  logic [DW/8-1:0]           s_w_strb;
  logic [1:0]                s_b_resp, s_r_resp;
  logic                      s_b_valid, s_b_ready, s_ar_valid, s_ar_ready;
  logic                      s_r_valid, s_r_ready;
  logic                      wr_busy_o, rd_busy_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  axi_lite_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot), .m_aw_valid(m_aw_valid),
    .m_aw_ready(m_aw_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_b_resp(m_b_resp),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_ar_addr(m_ar_addr),
    .m_ar_prot(m_ar_prot), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid),
    .m_r_ready(m_r_ready), .s_aw_addr(s_aw_addr), .s_aw_prot(s_aw_prot),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_w_data(s_w_data),
    .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_prot(s_ar_prot), .s_ar_valid(s_ar_valid),
    .s_ar_ready(s_ar_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .wr_busy_o(wr_busy_o),
    .rd_busy_o(rd_busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow a #1 settle.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    m_aw_addr = '0; m_aw_prot = '0; m_aw_valid = '0; m_w_data = '0; m_w_strb = '0;
    m_w_valid = '0; m_b_ready = '0; m_ar_addr = '0; m_ar_prot = '0; m_ar_valid = '0;
    m_r_ready = '0; s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_resp = '0; s_b_valid = 1'b0;
    s_ar_ready = 1'b0; s_r_data = '0; s_r_resp = '0; s_r_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    rst_ni = 1'b1;
  endtask

  // One contended write to granted master g; both masters keep requesting afterwards.
  task automatic wr_txn(input int g, input logic [1:0] resp);
    logic [N-1:0] gmask;
    gmask = N'(1) << g;
    cyc();
    #1;
    chk($sformatf("cont%0d_aw_addr", g), s_aw_addr, 64'h100 + 64'(g));
    chk($sformatf("cont%0d_aw_ready", g), m_aw_ready, gmask);
    chk($sformatf("cont%0d_w_ready", g), m_w_ready, gmask);
    cyc();
    m_aw_valid[g] = 1'b0;
    m_w_valid[g]  = 1'b0;
    s_b_valid     = 1'b1;
    s_b_resp      = resp;
    #1;
    chk($sformatf("cont%0d_b_valid", g), m_b_valid, gmask);
    chk($sformatf("cont%0d_b_resp_g", g), m_b_resp[g], resp);
    chk($sformatf("cont%0d_b_resp_other", g), m_b_resp[1-g], 2'b00);
    cyc();
    s_b_valid     = 1'b0;
    m_aw_valid[g] = 1'b1;
    m_w_valid[g]  = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_s_aw_valid", s_aw_valid, 0);
    chk("rst_s_w_valid", s_w_valid, 0);
    chk("rst_s_ar_valid", s_ar_valid, 0);
    chk("rst_busy", {wr_busy_o, rd_busy_o}, 0);
    chk("rst_m_readys", {m_aw_ready, m_w_ready, m_ar_ready}, 0);
    chk("rst_m_valids", {m_b_valid, m_r_valid}, 0);
    chk("rst_m_r_data", m_r_data[0] | m_r_data[1], 0);
    chk("rst_s_aw_addr", s_aw_addr, 0);

    // Single write from master 0
    m_aw_addr[0] = 64'h10; m_aw_valid[0] = 1'b1;
    m_w_data[0] = 64'hA5; m_w_strb[0] = 8'hFF; m_w_valid[0] = 1'b1;
    m_b_ready = 2'b11; s_aw_ready = 1'b1; s_w_ready = 1'b1;
    #1;
    chk("w1_c0_s_aw_valid", s_aw_valid, 0);
    cyc();
    #1;
    chk("w1_c1_valids", {s_aw_valid, s_w_valid}, 2'b11);
    chk("w1_c1_aw_addr", s_aw_addr, 64'h10);
    chk("w1_c1_w_data", s_w_data, 64'hA5);
    chk("w1_c1_w_strb", s_w_strb, 8'hFF);
    chk("w1_c1_m_readys", {m_aw_ready, m_w_ready}, 4'b0101);
    chk("w1_c1_wr_busy", wr_busy_o, 1);
    cyc();
    m_aw_valid = '0; m_w_valid = '0; s_b_valid = 1'b1; s_b_resp = 2'b00;
    #1;
    chk("w1_c2_b_valid", m_b_valid, 2'b01);
    chk("w1_c2_b_resp", m_b_resp, 4'b0000);
    chk("w1_c2_s_b_ready", s_b_ready, 1);
    chk("w1_c2_fwd_masked", {s_aw_valid, s_w_valid}, 0);
    cyc();
    s_b_valid = 1'b0;
    #1;
    chk("w1_c3_idle", {wr_busy_o, m_b_valid}, 0);

    // Contention: four back-to-back writes, both masters always requesting
    do_reset();
    m_aw_addr[0] = 64'h100; m_aw_addr[1] = 64'h101;
    m_aw_valid = 2'b11; m_w_valid = 2'b11; m_b_ready = 2'b11;
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    wr_txn(0, 2'b01);
    wr_txn(1, 2'b10);
    wr_txn(0, 2'b11);
    wr_txn(1, 2'b01);

    // Skewed AW/W: W handshakes first, AW ready held off for three cycles
    do_reset();
    m_aw_addr[0] = 64'h44; m_aw_valid[0] = 1'b1; m_w_valid[0] = 1'b1; m_b_ready = 2'b11;
    s_w_ready = 1'b1;
    cyc();
    #1;
    chk("skew_c1_valids", {s_aw_valid, s_w_valid}, 2'b11);
    chk("skew_c1_readys", {m_aw_ready, m_w_ready}, 4'b0001);
    cyc();
    m_w_valid[0] = 1'b0;
    #1;
    chk("skew_c2_valids", {s_aw_valid, s_w_valid}, 2'b10);
    chk("skew_c2_m_w_ready", m_w_ready, 0);
    cyc();
    #1;
    chk("skew_c3_not_resp", {s_b_ready, s_aw_valid, s_w_valid}, 3'b010);
    cyc();
    s_aw_ready = 1'b1;
    #1;
    chk("skew_c4_aw_ready", m_aw_ready, 2'b01);
    chk("skew_c4_not_resp", s_b_ready, 0);
    cyc();
    m_aw_valid[0] = 1'b0; s_aw_ready = 1'b0; s_b_valid = 1'b1;
    #1;
    chk("skew_c5_resp", {s_b_ready, m_b_valid, s_aw_valid, s_w_valid}, 5'b10100);
    cyc();
    s_b_valid = 1'b0;
    #1;
    chk("skew_c6_idle", {wr_busy_o, s_aw_valid, s_w_valid}, 0);
    // A lone W from master 1 must not start a write
    m_w_valid[1] = 1'b1;
    cyc();
    #1;
    chk("lone_w_no_grant", {wr_busy_o, s_aw_valid, s_w_valid, m_w_ready}, 0);
    m_w_valid[1] = 1'b0;

    // Concurrent read (master 0) and write (master 1)
    m_ar_addr[0] = 64'h20; m_ar_valid[0] = 1'b1; m_r_ready = 2'b11;
    m_aw_addr[1] = 64'h30; m_aw_valid[1] = 1'b1;
    m_w_data[1] = 64'h5A; m_w_valid[1] = 1'b1;
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_ar_ready = 1'b1;
    cyc();
    #1;
    chk("conc_c1_ar", {s_ar_valid, m_ar_ready}, 3'b101);
    chk("conc_c1_ar_addr", s_ar_addr, 64'h20);
    chk("conc_c1_aw", {s_aw_valid, m_aw_ready}, 3'b110);
    chk("conc_c1_aw_addr", s_aw_addr, 64'h30);
    chk("conc_c1_w_data", s_w_data, 64'h5A);
    cyc();
    m_ar_valid = '0; m_aw_valid = '0; m_w_valid = '0;
    s_r_valid = 1'b1; s_r_data = 64'h1234; s_r_resp = 2'b00;
    s_b_valid = 1'b1; s_b_resp = 2'b01;
    #1;
    chk("conc_c2_r_valid", m_r_valid, 2'b01);
    chk("conc_c2_r_data0", m_r_data[0], 64'h1234);
    chk("conc_c2_r_data1", m_r_data[1], 0);
    chk("conc_c2_b_valid", m_b_valid, 2'b10);
    chk("conc_c2_b_resp", m_b_resp, 4'b0100);
    cyc();
    s_r_valid = 1'b0; s_b_valid = 1'b0;
    #1;
    chk("conc_c3_idle", {wr_busy_o, rd_busy_o, m_r_valid, m_b_valid}, 0);

    // Backpressure: master 0 holds off R for five cycles while master 1 waits on AR
    do_reset();
    m_ar_addr[0] = 64'h40; m_ar_valid[0] = 1'b1; s_ar_ready = 1'b1;
    cyc();
    #1;
    chk("bp_ar_addr", s_ar_addr, 64'h40);
    cyc();
    m_ar_valid[0] = 1'b0;
    m_ar_addr[1] = 64'h50; m_ar_valid[1] = 1'b1;
    s_r_valid = 1'b1; s_r_data = 64'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d_r_valid", i), m_r_valid, 2'b01);
      chk($sformatf("bp%0d_r_data", i), m_r_data[0], 64'hBEEF);
      chk($sformatf("bp%0d_ar_wait", i), {m_ar_ready, s_ar_valid, s_r_ready}, 0);
      chk($sformatf("bp%0d_rd_busy", i), rd_busy_o, 1);
      cyc();
    end

    // Reset in R_DATA: one reset cycle, then grant restarts at master 0
    rst_ni = 1'b0; s_r_valid = 1'b0; s_r_data = '0;
    cyc();
    #1;
    chk("rr_rd_busy", rd_busy_o, 0);
    chk("rr_m_r", {m_r_valid, m_ar_ready, s_ar_valid, s_r_ready}, 0);
    chk("rr_m_r_data", m_r_data[0] | m_r_data[1], 0);
    rst_ni = 1'b1;
    m_ar_addr[0] = 64'h60; m_ar_valid = 2'b11;
    cyc();
    #1;
    chk("rr_next_grant", m_ar_ready, 2'b01);
    chk("rr_next_addr", s_ar_addr, 64'h60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
